// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   Turns a raw asynchronous push-button/switch input into a clean,
//   clk-synchronous level. The input first passes through a flop-chain
//   synchroniser. A four-state FSM then accepts a change of level only after
//   STABLE_CYCLES consecutive equal synchronised samples. Every accepted change
//   produces a one-cycle rise or fall strobe.
//
// Parameters
//   SYNC_STAGES   synchroniser depth (>= 2)
//   STABLE_CYCLES equal synchronised samples needed to accept a change (>= 2)
//   CNT_W         stability counter width (2**CNT_W > STABLE_CYCLES)
//
// Ports
//   clk         in  single clock, all logic on posedge
//   rst         in  synchronous active-low reset
//   btn_in      in  raw asynchronous input
//   d_out       out debounced level (registered)
//   rise_pulse  out one-cycle strobe in the first cycle d_out reads 1
//   fall_pulse  out one-cycle strobe in the first cycle d_out reads 0
//   busy        out high while a level change is being qualified
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Count value reached on the last sample of the stability window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q_s;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nx_s;
  logic                   d_out_r;
  logic                   d_out_nx_s;
  logic                   rise_r;
  logic                   rise_nx_s;
  logic                   fall_r;
  logic                   fall_nx_s;
  logic                   busy_r;
  logic                   busy_nx_s;

  assign sync_q_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain: btn_in enters stage 0, the FSM reads only the last stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Next-state and next-output decode for the qualification FSM.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    d_out_nx_s = d_out_r;
    rise_nx_s  = 1'b0;
    fall_nx_s  = 1'b0;

    case (state_r)
      S_LOW: begin
        if (sync_q_s) begin
          state_nx_s = S_WAIT_HI;
          cnt_nx_s   = CNT_ONE;
        end else begin
          cnt_nx_s   = CNT_ZERO;
        end
      end

      S_WAIT_HI: begin
        if (!sync_q_s) begin
          // Bounce: drop back without touching d_out.
          state_nx_s = S_LOW;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = S_HIGH;
          cnt_nx_s   = CNT_ZERO;
          d_out_nx_s = 1'b1;
          rise_nx_s  = 1'b1;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end

      S_HIGH: begin
        if (!sync_q_s) begin
          state_nx_s = S_WAIT_LO;
          cnt_nx_s   = CNT_ONE;
        end else begin
          cnt_nx_s   = CNT_ZERO;
        end
      end

      S_WAIT_LO: begin
        if (sync_q_s) begin
          // Glitch: return to the stable high state.
          state_nx_s = S_HIGH;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = S_LOW;
          cnt_nx_s   = CNT_ZERO;
          d_out_nx_s = 1'b0;
          fall_nx_s  = 1'b1;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_nx_s = S_LOW;
        cnt_nx_s   = CNT_ZERO;
        d_out_nx_s = 1'b0;
      end
    endcase

    // Registering the decode of the next state gives the same timing as
    // decoding the state register, but keeps busy a flop output.
    busy_nx_s = (state_nx_s == S_WAIT_HI) || (state_nx_s == S_WAIT_LO);
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_LOW;
      cnt_r   <= CNT_ZERO;
      d_out_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      d_out_r <= d_out_nx_s;
      rise_r  <= rise_nx_s;
      fall_r  <= fall_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign d_out      = d_out_r;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//   Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4.
//   Expected values are hand-derived edge by edge; edge 1 is the first posedge
//   after btn_in changes. Outputs are sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  logic clk;
  logic rst;
  logic btn_in;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int err_cnt_r;
  int chk_cnt_r;

  debounce_sync #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt_r = chk_cnt_r + 1;
    if (obs !== exp) begin
      err_cnt_r = err_cnt_r + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one posedge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_d, input logic e_r,
                            input logic e_f, input logic e_b);
    check({tag, ".d_out"}, {31'd0, d_out},      {31'd0, e_d});
    check({tag, ".rise"},  {31'd0, rise_pulse}, {31'd0, e_r});
    check({tag, ".fall"},  {31'd0, fall_pulse}, {31'd0, e_f});
    check({tag, ".busy"},  {31'd0, busy},       {31'd0, e_b});
  endtask

  int busy_cycles;
  int busy_bursts;
  logic busy_prev;

  initial begin
    err_cnt_r = 0;
    chk_cnt_r = 0;
    rst       = 1'b0;
    btn_in    = 1'b1;

    // 1: reset held for 3 edges with btn_in high.
    for (int k = 1; k <= 3; k++) begin
      step();
      check_outs($sformatf("reset_e%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Idle low so the press below starts from a quiet input.
    btn_in = 1'b0;
    rst    = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_outs($sformatf("idle_e%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 2: clean press; d_out rises after edge 6, busy after edges 3..5.
    btn_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check_outs($sformatf("press_e%0d", k), (k >= 6), (k == 6), 1'b0,
                 (k >= 3 && k <= 5));
    end

    // 5: one-cycle low glitch while high; busy only after edge 3.
    btn_in = 1'b0;
    step();
    check_outs("glitch_e1", 1'b1, 1'b0, 1'b0, 1'b0);
    btn_in = 1'b1;
    for (int k = 2; k <= 7; k++) begin
      step();
      check_outs($sformatf("glitch_e%0d", k), 1'b1, 1'b0, 1'b0, (k == 3));
    end

    // 4: release; d_out falls after edge 6 with a single fall strobe.
    btn_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check_outs($sformatf("release_e%0d", k), (k < 6), 1'b0, (k == 6),
                 (k >= 3 && k <= 5));
    end

    // 3: bounce, 3 cycles high / 2 low, five times; never qualifies.
    busy_cycles = 0;
    busy_bursts = 0;
    busy_prev   = 1'b0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 5; c++) begin
        btn_in = (c < 3);
        step();
        check_outs($sformatf("bounce_r%0d_c%0d", rep, c), 1'b0, 1'b0, 1'b0, busy);
        if (busy) busy_cycles++;
        if (busy && !busy_prev) busy_bursts++;
        busy_prev = busy;
      end
    end
    btn_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_outs($sformatf("bounce_tail%0d", k), 1'b0, 1'b0, 1'b0, busy);
      if (busy) busy_cycles++;
      if (busy && !busy_prev) busy_bursts++;
      busy_prev = busy;
    end
    check("bounce_busy_cycles", busy_cycles, 32'd15);
    check("bounce_busy_bursts", busy_bursts, 32'd5);
    check("bounce_busy_end", {31'd0, busy}, 32'd0);

    // 6: press, then reset lands on edge 4 while still qualifying.
    btn_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_outs($sformatf("abort_e%0d", k), 1'b0, 1'b0, 1'b0, (k == 3));
    end
    rst = 1'b0;
    step();
    check_outs("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_outs($sformatf("requal_e%0d", k), (k >= 6), (k == 6), 1'b0,
                 (k >= 3 && k <= 5));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt_r, chk_cnt_r);
    $finish;
  end

endmodule
